vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing (hsync, vsync, display enable, pixel coordinates, line/frame strobes) from the 25 MHz pixel clock. Sits directly downstream of the pixel clock generator: it is clocked by `clk_pix`, gated by that block's `locked`, and feeds the pixel/colour stage and the VGA output pins. Defaults implement 640x480 @ 60 Hz.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: sync polarity; 0 = active-low, 1 = active-high (applies to both syncs)

Ports:
- `clk_pix` in 1: pixel clock; the only clock
- `reset` in 1: synchronous, active-high reset
- `locked` in 1: pixel clock valid; timing runs only while high
- `hsync` out 1: horizontal sync, polarity per `SYNC_POL`
- `vsync` out 1: vertical sync, polarity per `SYNC_POL`
- `de` out 1: display enable, high inside the active region
- `sx` out 10: current pixel column, 0..H_TOTAL-1
- `sy` out 10: current line, 0..V_TOTAL-1
- `line_start` out 1: one-cycle strobe at `sx`==0
- `frame_start` out 1: one-cycle strobe at `sx`==0, `sy`==0

## Operation
- `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP (800). `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024. Counters are 10-bit unsigned.
- The `running` register samples `locked` on every clock. `reset` clears `running` and both counters.
- While `running`=0:
  - `h_cnt` and `v_cnt` are held at 0.
  - All outputs are idle: sync deasserted (level = ~active), `de`=0, `sx`=`sy`=0, strobes 0.
- While `running`=1, `h_cnt` increments every clock.
  - At `h_cnt`==H_TOTAL-1: `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `v_cnt`==V_TOTAL-1 on that same clock: `v_cnt` also wraps to 0.
- Decode, all gated by `running`:
  - `de` = (`h_cnt`<H_ACTIVE) && (`v_cnt`<V_ACTIVE)
  - hsync active for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751
  - vsync active for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491
  - `sx`=`h_cnt`, `sy`=`v_cnt`
  - `line_start` = (`h_cnt`==0)
  - `frame_start` = (`h_cnt`==0 && `v_cnt`==0)
- `locked` falling mid-frame: `running` clears on the next clock. Counters return to 0 and outputs go idle on that same clock. No partial-frame state is retained.
- `locked` rising: `running` sets on the next clock, and the raster starts at (0,0) with `frame_start`=1.
- `reset` has priority over `locked`.

## Timing
- Reset values, all outputs: `hsync`=`vsync`=~SYNC_POL (1 by default), `de`=0, `sx`=0, `sy`=0, `line_start`=0, `frame_start`=0.
- Latency from `locked` to first `frame_start`:
  - 1 clock without the output register.
  - 2 clocks with `VGA_TIMING_REG_OUT_EN`.
- Line period is 800 clocks; frame period is 420000 clocks.
- `line_start` and `frame_start` are each exactly one clock wide.
- `frame_start` coincides with a `line_start`.
- All outputs are mutually cycle-aligned in both configurations.

## Configuration
- `VGA_TIMING_REG_OUT_EN` defined:
  - All seven outputs come from a register stage fed by the decode, adding 1 clock latency.
  - The register stage is reset to the idle values above.
  - Glitch-free outputs, suitable for driving pins directly.
- Not defined:
  - Outputs are combinational decode of `running` and the counters, with 0 added latency.
  - Reset/idle values are identical to the registered configuration.

## Test plan
- Reset with `locked`=1, then release → all outputs at idle values during reset; `frame_start` pulses 1 clock after release (2 with `VGA_TIMING_REG_OUT_EN`), then `sx` counts 0,1,2…
- Run one full line → `de` high for exactly 640 clocks; `hsync` low for 96 clocks starting at `sx`=656; `line_start` period 800 clocks.
- Run one full frame → `vsync` low during `sy`=490..491 (1600 clocks); `frame_start` period 420000 clocks; `sx`=799,`sy`=524 is followed by 0,0.
- Drop `locked` at `sx`=300,`sy`=200, hold 5 clocks, raise → outputs idle the clock after the drop; raster restarts at (0,0) with `frame_start`.
- Assert `reset` mid-frame while `locked`=1 → outputs idle for the whole reset; restart at (0,0) one clock after release.
- `SYNC_POL`=1 build → `hsync`/`vsync` idle at 0 and pulse high over the same counter ranges.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (hsync/vsync/de, pixel coordinates, line/frame strobes).
// Define VGA_TIMING_REG_OUT_EN to drive all outputs from a register stage (+1 clock latency).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DE_END   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_DE_END   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          running_q, running_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  logic          hsync_c, vsync_c, de_c, line_start_c, frame_start_c;
  logic [CW-1:0] sx_c, sy_c;
  logic          h_act, v_act;

  // State registers
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      running_q <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      running_q <= running_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Counters advance only when running now and next; any drop of locked zeroes them at once
  always_comb begin
    running_d = locked;
    h_cnt_d   = '0;
    v_cnt_d   = '0;
    if (running_d && running_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // Raster decode, idle whenever not running
  always_comb begin
    h_act         = running_q && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    v_act         = running_q && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    hsync_c       = ~(h_act ^ SYNC_POL);
    vsync_c       = ~(v_act ^ SYNC_POL);
    de_c          = running_q && (h_cnt_q < H_DE_END) && (v_cnt_q < V_DE_END);
    sx_c          = running_q ? h_cnt_q : '0;
    sy_c          = running_q ? v_cnt_q : '0;
    line_start_c  = running_q && (h_cnt_q == '0);
    frame_start_c = line_start_c && (v_cnt_q == '0);
  end

`ifdef VGA_TIMING_REG_OUT_EN
  // Output register stage for glitch-free pins
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      de          <= de_c;
      sx          <= sx_c;
      sy          <= sy_c;
      line_start  <= line_start_c;
      frame_start <= frame_start_c;
    end
  end
`else
  assign hsync       = hsync_c;
  assign vsync       = vsync_c;
  assign de          = de_c;
  assign sx          = sx_c;
  assign sy          = sy_c;
  assign line_start  = line_start_c;
  assign frame_start = frame_start_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 instance plus a tiny active-high-sync instance,
// checked against an elapsed-pixel-count reference model and spec constants.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       ls;
    logic       fs;
  } vout_t;

  localparam vout_t IDLE_B = '{hs: 1'b1, vs: 1'b1, de: 1'b0, sx: 10'd0, sy: 10'd0, ls: 1'b0, fs: 1'b0};
  localparam vout_t IDLE_S = '{hs: 1'b0, vs: 1'b0, de: 1'b0, sx: 10'd0, sy: 10'd0, ls: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic locked = 1'b1;

  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_sx, b_sy;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_sx, s_sy;
  vout_t      b_act, s_act;

  assign b_act = {b_hs, b_vs, b_de, b_sx, b_sy, b_ls, b_fs};
  assign s_act = {s_hs, s_vs, s_de, s_sx, s_sy, s_ls, s_fs};

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk_pix(clk), .reset(reset), .locked(locked),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .sx(b_sx), .sy(b_sy),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // 15 x 8 raster, 120 clocks per frame, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk_pix(clk), .reset(reset), .locked(locked),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .sx(s_sx), .sy(s_sy),
    .line_start(s_ls), .frame_start(s_fs)
  );

  // Expected outputs from the number of pixels elapsed since the raster (re)started
  function automatic vout_t ref_out(input bit run, input int t,
                                    input int ha, input int hf, input int hs, input int hb,
                                    input int va, input int vf, input int vs, input int vb,
                                    input bit pol);
    vout_t r;
    int x, y;
    bit hact, vact;
    x = t % (ha + hf + hs + hb);
    y = (t / (ha + hf + hs + hb)) % (va + vf + vs + vb);
    if (!run) begin
      x = 0;
      y = 0;
    end
    hact = run && (x >= ha + hf) && (x < ha + hf + hs);
    vact = run && (y >= va + vf) && (y < va + vf + vs);
    r.hs = pol ? hact : !hact;
    r.vs = pol ? vact : !vact;
    r.de = run && (x < ha) && (y < va);
    r.sx = 10'(x);
    r.sy = 10'(y);
    r.ls = run && (x == 0);
    r.fs = run && (x == 0) && (y == 0);
    return r;
  endfunction

  function automatic vout_t ref_b(input bit run, input int t);
    return ref_out(run, t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic vout_t ref_s(input bit run, input int t);
    return ref_out(run, t, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
  endfunction

  bit    m_run = 1'b0;
  int    m_t   = 0;
  vout_t m_big = IDLE_B;
  vout_t m_sm  = IDLE_S;

  // Reference model: running follows locked one clock later; elapsed count restarts on (re)start
  always @(posedge clk) begin
    m_run <= !reset && locked;
    m_t   <= (!reset && locked && m_run) ? m_t + 1 : 0;
`ifdef VGA_TIMING_REG_OUT_EN
    m_big <= reset ? ref_b(1'b0, 0) : ref_b(m_run, m_t);
    m_sm  <= reset ? ref_s(1'b0, 0) : ref_s(m_run, m_t);
`else
    m_big <= ref_b(!reset && locked, (!reset && locked && m_run) ? m_t + 1 : 0);
    m_sm  <= ref_s(!reset && locked, (!reset && locked && m_run) ? m_t + 1 : 0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchecks++;
      if (b_act !== IDLE_B) begin nerr++; $display("FAIL reset_idle_big got %h exp %h", b_act, IDLE_B); end
      nchecks++;
      if (s_act !== IDLE_S) begin nerr++; $display("FAIL reset_idle_small got %h exp %h", s_act, IDLE_S); end
    end
    reset = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i < LAT) begin
        nchecks++;
        if (b_fs !== 1'b0) begin nerr++; $display("FAIL reset_early_fs got %b exp 0", b_fs); end
      end else begin
        nchecks++;
        if (b_fs !== 1'b1 || b_sx !== 10'd0 || b_sy !== 10'd0)
          begin nerr++; $display("FAIL reset_first_frame got fs=%b sx=%0d sy=%0d exp 1,0,0", b_fs, b_sx, b_sy); end
        nchecks++;
        if (s_fs !== 1'b1) begin nerr++; $display("FAIL reset_first_frame_small got %b exp 1", s_fs); end
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      nchecks++;
      if (b_sx !== 10'(k)) begin nerr++; $display("FAIL reset_sx_count got %0d exp %0d", b_sx, k); end
    end
  endtask

  task automatic test_line();
    int n = 0, de_n = 0, hs_n = 0, ls_n = 0, hs_first = -1;
    while (b_ls !== 1'b1 && n < 1000) begin tick(); n++; end
    nchecks++;
    if (b_ls !== 1'b1) begin nerr++; $display("FAIL line_wait timeout got ls=%b exp 1", b_ls); return; end
    for (int i = 0; i < 800; i++) begin
      if (b_de === 1'b1) de_n++;
      if (b_hs === 1'b0) begin
        if (hs_n == 0) hs_first = int'(b_sx);
        hs_n++;
      end
      if (b_ls === 1'b1) ls_n++;
      tick();
    end
    nchecks++;
    if (de_n != 640) begin nerr++; $display("FAIL line_de_width got %0d exp 640", de_n); end
    nchecks++;
    if (hs_n != 96) begin nerr++; $display("FAIL line_hsync_width got %0d exp 96", hs_n); end
    nchecks++;
    if (hs_first != 656) begin nerr++; $display("FAIL line_hsync_start got %0d exp 656", hs_first); end
    nchecks++;
    if (ls_n != 1) begin nerr++; $display("FAIL line_ls_count got %0d exp 1", ls_n); end
    nchecks++;
    if (b_ls !== 1'b1 || b_sx !== 10'd0)
      begin nerr++; $display("FAIL line_period got ls=%b sx=%0d exp 1,0", b_ls, b_sx); end
  endtask

  task automatic test_frame();
    int n = 0, vs_n = 0, hs_n = 0, fs_n = 0, de_n = 0, vs_first = -1, wraps = 0;
    logic [9:0] px, py;
    while (s_fs !== 1'b1 && n < 300) begin tick(); n++; end
    nchecks++;
    if (s_fs !== 1'b1) begin nerr++; $display("FAIL frame_wait timeout got fs=%b exp 1", s_fs); return; end
    for (int i = 0; i < 120; i++) begin
      if (s_vs === 1'b1) begin
        if (vs_n == 0) vs_first = int'(s_sy);
        vs_n++;
      end
      if (s_hs === 1'b1) hs_n++;
      if (s_de === 1'b1) de_n++;
      if (s_fs === 1'b1) fs_n++;
      px = s_sx;
      py = s_sy;
      tick();
      if (px == 10'd14 && py == 10'd7) begin
        wraps++;
        nchecks++;
        if (s_sx !== 10'd0 || s_sy !== 10'd0)
          begin nerr++; $display("FAIL frame_wrap got sx=%0d sy=%0d exp 0,0", s_sx, s_sy); end
      end
    end
    nchecks++;
    if (vs_n != 30) begin nerr++; $display("FAIL frame_vsync_width got %0d exp 30", vs_n); end
    nchecks++;
    if (vs_first != 5) begin nerr++; $display("FAIL frame_vsync_line got %0d exp 5", vs_first); end
    nchecks++;
    if (hs_n != 24) begin nerr++; $display("FAIL frame_hsync_total got %0d exp 24", hs_n); end
    nchecks++;
    if (de_n != 32) begin nerr++; $display("FAIL frame_de_total got %0d exp 32", de_n); end
    nchecks++;
    if (fs_n != 1 || wraps != 1) begin nerr++; $display("FAIL frame_fs_count got fs=%0d wraps=%0d exp 1,1", fs_n, wraps); end
    nchecks++;
    if (s_fs !== 1'b1) begin nerr++; $display("FAIL frame_period got fs=%b exp 1", s_fs); end
  endtask

  task automatic test_locked_drop();
    int n = 0;
    while (b_sx !== 10'd300 && n < 1000) begin tick(); n++; end
    nchecks++;
    if (b_sx !== 10'd300) begin nerr++; $display("FAIL drop_wait timeout got sx=%0d exp 300", b_sx); return; end
    locked = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= LAT) begin
        nchecks++;
        if (b_act !== IDLE_B) begin nerr++; $display("FAIL drop_idle_big cyc=%0d got %h exp %h", i, b_act, IDLE_B); end
        nchecks++;
        if (s_act !== IDLE_S) begin nerr++; $display("FAIL drop_idle_small cyc=%0d got %h exp %h", i, s_act, IDLE_S); end
      end
    end
    locked = 1'b1;
    repeat (LAT) tick();
    nchecks++;
    if (b_fs !== 1'b1 || b_sx !== 10'd0 || b_sy !== 10'd0)
      begin nerr++; $display("FAIL drop_restart got fs=%b sx=%0d sy=%0d exp 1,0,0", b_fs, b_sx, b_sy); end
    nchecks++;
    if (s_fs !== 1'b1) begin nerr++; $display("FAIL drop_restart_small got %b exp 1", s_fs); end
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(50, 500)) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nchecks++;
      if (b_act !== IDLE_B) begin nerr++; $display("FAIL midreset_idle_big got %h exp %h", b_act, IDLE_B); end
      nchecks++;
      if (s_act !== IDLE_S) begin nerr++; $display("FAIL midreset_idle_small got %h exp %h", s_act, IDLE_S); end
    end
    reset = 1'b0;
    repeat (LAT) tick();
    nchecks++;
    if (b_fs !== 1'b1 || b_sx !== 10'd0 || b_sy !== 10'd0)
      begin nerr++; $display("FAIL midreset_restart got fs=%b sx=%0d sy=%0d exp 1,0,0", b_fs, b_sx, b_sy); end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        if (locked && $urandom_range(0, 1) == 0) begin
          locked = 1'b0;
          hold   = int'($urandom_range(1, 6));
        end else begin
          locked = 1'b1;
          hold   = int'($urandom_range(50, 1500));
        end
      end
      hold--;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      nchecks++;
      if (b_act !== m_big) begin nerr++; $display("FAIL rand_big cyc=%0d got %h exp %h", i, b_act, m_big); end
      nchecks++;
      if (s_act !== m_sm) begin nerr++; $display("FAIL rand_small cyc=%0d got %h exp %h", i, s_act, m_sm); end
    end
    reset  = 1'b0;
    locked = 1'b1;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_locked_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
